// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module   : down_counter
// Brief    : Loadable synchronous decrementer with registered borrow pulse,
//            zero flag, sticky underflow flag and busy status.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter #(
    parameter int WIDTH = 2,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] diff,
    output logic             stat,
    output logic             zero,
    output logic             sticky,
    output logic             busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_diff;
    logic             r_stat;
    logic             r_zero;
    logic             r_sticky;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_diff_nxt;
    logic             w_underflow;
    logic             w_sticky_nxt;

    // Load takes priority over a same-cycle decrement; borrow is detected
    // as an enabled decrement from zero, not from a subtraction sign bit.
    always_comb begin
        w_state_nxt = r_state;
        w_diff_nxt  = r_diff;
        w_underflow = 1'b0;
        if (load) begin
            w_state_nxt = c_run;
            w_diff_nxt  = load_val;
        end else if (r_state == c_run && en) begin
            if (r_diff != '0) begin
                w_diff_nxt = r_diff - c_one;
            end else begin
                w_underflow = 1'b1;
                if (WRAP != 0) begin
                    w_diff_nxt = c_max;
                end else begin
                    w_state_nxt = c_done;
                end
            end
        end
    end

    // A simultaneous underflow beats clr_stat.
    always_comb begin
        w_sticky_nxt = r_sticky;
        if (w_underflow) begin
            w_sticky_nxt = 1'b1;
        end else if (clr_stat) begin
            w_sticky_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_diff   <= '0;
            r_stat   <= 1'b0;
            r_zero   <= 1'b1;
            r_sticky <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_diff   <= w_diff_nxt;
            r_stat   <= w_underflow;
            r_zero   <= (w_diff_nxt == '0);
            r_sticky <= w_sticky_nxt;
            r_busy   <= (w_state_nxt == c_run);
        end
    end

    assign diff   = r_diff;
    assign stat   = r_stat;
    assign zero   = r_zero;
    assign sticky = r_sticky;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_counter
// Brief    : Scoreboard bench for down_counter, wrapping and saturating builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [1:0] load_val;
    logic       en;
    logic       clr_stat;

    logic [1:0] diff_w, diff_s;
    logic       stat_w, stat_s;
    logic       zero_w, zero_s;
    logic       sticky_w, sticky_s;
    logic       busy_w, busy_s;

    int n_checks;
    int n_fail;

    // Expected entries are {diff[1:0], stat, zero, sticky, busy}.
    logic [5:0] q_exp[$];

    down_counter #(.WIDTH(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .clr_stat(clr_stat), .diff(diff_w), .stat(stat_w), .zero(zero_w),
        .sticky(sticky_w), .busy(busy_w)
    );

    down_counter #(.WIDTH(2), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .clr_stat(clr_stat), .diff(diff_s), .stat(stat_s), .zero(zero_s),
        .sticky(sticky_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] obs_w = {diff_w, stat_w, zero_w, sticky_w, busy_w};
    wire [5:0] obs_s = {diff_s, stat_s, zero_s, sticky_s, busy_s};

    // Stimulus word is {rst, load, load_val[1:0], en, clr_stat}.
    task automatic drive(input logic [5:0] s);
        {rst, load, load_val, en, clr_stat} = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [5:0] stim [5];
        logic [5:0] exp_w, exp_s;
        stim = '{6'b100000, 6'b100000, 6'b000010, 6'b000010, 6'b000010};
        for (int i = 0; i < 5; i++) begin
            q_exp.push_back(6'b000100);
            q_exp.push_back(6'b000100);
            drive(stim[i]);
            exp_w = q_exp.pop_front();
            exp_s = q_exp.pop_front();
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL reset_idle_wrap step %0d: got %b expected %b", i, obs_w, exp_w);
            end
            n_checks++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL reset_idle_sat step %0d: got %b expected %b", i, obs_s, exp_s);
            end
        end
    endtask

    task automatic test_wrap_countdown;
        logic [5:0] stim [6];
        logic [5:0] expv [6];
        logic [5:0] e;
        stim = '{6'b011100, 6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
        expv = '{6'b110001, 6'b100001, 6'b010001, 6'b000101, 6'b111011, 6'b100011};
        for (int i = 0; i < 6; i++) begin
            q_exp.push_back(expv[i]);
            drive(stim[i]);
            e = q_exp.pop_front();
            n_checks++;
            if (obs_w !== e) begin
                n_fail++;
                $display("FAIL wrap_countdown step %0d: got %b expected %b", i, obs_w, e);
            end
        end
    endtask

    task automatic test_load_over_decrement;
        logic [5:0] e;
        q_exp.push_back(6'b010011);
        drive(6'b010110);
        e = q_exp.pop_front();
        n_checks++;
        if (obs_w !== e) begin
            n_fail++;
            $display("FAIL load_over_en: got %b expected %b", obs_w, e);
        end
    endtask

    task automatic test_sticky_race;
        logic [5:0] stim [3];
        logic [5:0] expv [3];
        logic [5:0] e;
        stim = '{6'b000010, 6'b000011, 6'b000001};
        expv = '{6'b000111, 6'b111011, 6'b110001};
        for (int i = 0; i < 3; i++) begin
            q_exp.push_back(expv[i]);
            drive(stim[i]);
            e = q_exp.pop_front();
            n_checks++;
            if (obs_w !== e) begin
                n_fail++;
                $display("FAIL sticky_race step %0d: got %b expected %b", i, obs_w, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] stim [7];
        logic [5:0] expv [7];
        logic [5:0] e;
        stim = '{6'b010000, 6'b000010, 6'b000010, 6'b000010,
                 6'b100010, 6'b000010, 6'b000010};
        expv = '{6'b000101, 6'b111011, 6'b100011, 6'b010011,
                 6'b000100, 6'b000100, 6'b000100};
        for (int i = 0; i < 7; i++) begin
            q_exp.push_back(expv[i]);
            drive(stim[i]);
            e = q_exp.pop_front();
            n_checks++;
            if (obs_w !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %b expected %b", i, obs_w, e);
            end
        end
    endtask

    task automatic test_saturate;
        logic [5:0] stim [7];
        logic [5:0] expv [7];
        logic [5:0] e;
        stim = '{6'b100000, 6'b010100, 6'b000010, 6'b000010,
                 6'b000010, 6'b000010, 6'b011000};
        expv = '{6'b000100, 6'b010001, 6'b000101, 6'b001110,
                 6'b000110, 6'b000110, 6'b100011};
        for (int i = 0; i < 7; i++) begin
            q_exp.push_back(expv[i]);
            drive(stim[i]);
            e = q_exp.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL saturate step %0d: got %b expected %b", i, obs_s, e);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        {rst, load, load_val, en, clr_stat} = 6'b100000;
        test_reset();
        test_wrap_countdown();
        test_load_over_decrement();
        test_sticky_race();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
